// File: rtl/eggtimer_pkg.sv
// Shared egg-timer constants: BCD digit width, MM:SS packing
// and field offsets used by the countdown datapath.
package eggtimer_pkg;

  localparam int DIGIT_W = 4;
  localparam int TIME_W  = 16;

  localparam int SEC_ONES_LSB = 0;
  localparam int SEC_TENS_LSB = 4;
  localparam int MIN_ONES_LSB = 8;
  localparam int MIN_TENS_LSB = 12;

  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;
  localparam logic [TIME_W-1:0]  ZERO_TIME    = 16'h0000;
  localparam logic [TIME_W-1:0]  ONE_SEC      = 16'h0001;

  typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/sec_prescaler.sv
// One-second tick generator: counts 0..TICK_DIV-1 while run=1.
// Ports: clk, reset (async high), run in; sec_tick out.
module sec_prescaler
  import eggtimer_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sec_tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last  = (cnt == LAST);
  assign sec_tick = run & at_last;

  // Dropping run parks the phase at 0, so a fresh run
  // always waits a full TICK_DIV before the first tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (!run || at_last)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/countdown_datapath.sv
// Egg-timer datapath: BCD setting registers, MM:SS countdown,
// 1 Hz tick and display mux.
// Ports: clk, reset (async high), prog_mode, increment_seconds,
// increment_minutes, load_timer, main_timer_enable in;
// timer_done, sec_tick, set_time, count_time, display_time out.
// Optional: COUNTDOWN_ALARM_EN adds the alarm output.
module countdown_datapath
  import eggtimer_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_mode,
  input  logic              increment_seconds,
  input  logic              increment_minutes,
  input  logic              load_timer,
  input  logic              main_timer_enable,
  output logic              timer_done,
  output logic              sec_tick,
  output logic [TIME_W-1:0] set_time,
  output logic [TIME_W-1:0] count_time,
  output logic [TIME_W-1:0] display_time
`ifdef COUNTDOWN_ALARM_EN
  ,
  output logic              alarm
`endif
);

  function automatic digit_t inc_wrap(
    input digit_t d,
    input digit_t max
  );
    return (d == max) ? '0 : d + 4'd1;
  endfunction

  function automatic digit_t dec_wrap(
    input digit_t d,
    input digit_t max
  );
    return (d == '0) ? max : d - 4'd1;
  endfunction

  function automatic logic [TIME_W-1:0] step_sec(
    input logic [TIME_W-1:0] t
  );
    logic [TIME_W-1:0] r;
    digit_t o, tn;
    r  = t;
    o  = t[SEC_ONES_LSB +: DIGIT_W];
    tn = t[SEC_TENS_LSB +: DIGIT_W];
    r[SEC_ONES_LSB +: DIGIT_W] = inc_wrap(o, DIGIT_MAX);
    if (o == DIGIT_MAX)
      r[SEC_TENS_LSB +: DIGIT_W] = inc_wrap(tn, SEC_TENS_MAX);
    return r;
  endfunction

  function automatic logic [TIME_W-1:0] step_min(
    input logic [TIME_W-1:0] t
  );
    logic [TIME_W-1:0] r;
    digit_t o, tn;
    r  = t;
    o  = t[MIN_ONES_LSB +: DIGIT_W];
    tn = t[MIN_TENS_LSB +: DIGIT_W];
    r[MIN_ONES_LSB +: DIGIT_W] = inc_wrap(o, DIGIT_MAX);
    if (o == DIGIT_MAX)
      r[MIN_TENS_LSB +: DIGIT_W] = inc_wrap(tn, DIGIT_MAX);
    return r;
  endfunction

  // Caller guarantees t != 0, so min_tens never underflows.
  function automatic logic [TIME_W-1:0] dec_time(
    input logic [TIME_W-1:0] t
  );
    logic [TIME_W-1:0] r;
    logic b;
    r = t;
    b = (t[SEC_ONES_LSB +: DIGIT_W] == '0);
    r[SEC_ONES_LSB +: DIGIT_W] =
      dec_wrap(t[SEC_ONES_LSB +: DIGIT_W], DIGIT_MAX);
    if (b) begin
      b = (t[SEC_TENS_LSB +: DIGIT_W] == '0);
      r[SEC_TENS_LSB +: DIGIT_W] =
        dec_wrap(t[SEC_TENS_LSB +: DIGIT_W], SEC_TENS_MAX);
    end
    if (b) begin
      b = (t[MIN_ONES_LSB +: DIGIT_W] == '0);
      r[MIN_ONES_LSB +: DIGIT_W] =
        dec_wrap(t[MIN_ONES_LSB +: DIGIT_W], DIGIT_MAX);
    end
    if (b)
      r[MIN_TENS_LSB +: DIGIT_W] =
        t[MIN_TENS_LSB +: DIGIT_W] - 4'd1;
    return r;
  endfunction

  logic              sec_prev;
  logic              min_prev;
  logic              sec_fire;
  logic              min_fire;
  logic              dec_en;
  logic [TIME_W-1:0] set_q;
  logic [TIME_W-1:0] set_next;
  logic [TIME_W-1:0] cnt_q;
  logic [TIME_W-1:0] cnt_next;

  sec_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk      (clk),
    .reset    (reset),
    .run      (main_timer_enable & ~load_timer),
    .sec_tick (sec_tick)
  );

  // Edge registers sample regardless of prog_mode so a
  // request held across prog_mode rising is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_prev <= 1'b0;
      min_prev <= 1'b0;
    end else begin
      sec_prev <= increment_seconds;
      min_prev <= increment_minutes;
    end
  end

  assign sec_fire = prog_mode & increment_seconds & ~sec_prev;
  assign min_fire = prog_mode & increment_minutes & ~min_prev;
  assign dec_en   = sec_tick & ~load_timer & (cnt_q != ZERO_TIME);

  always_comb begin
    set_next = set_q;
    if (sec_fire)
      set_next = step_sec(set_next);
    if (min_fire)
      set_next = step_min(set_next);
  end

  // Load copies the registered setting, i.e. the value before
  // any increment landing on the same edge.
  always_comb begin
    cnt_next = cnt_q;
    if (load_timer)
      cnt_next = set_q;
    else if (dec_en)
      cnt_next = dec_time(cnt_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      set_q <= ZERO_TIME;
      cnt_q <= ZERO_TIME;
    end else begin
      set_q <= set_next;
      cnt_q <= cnt_next;
    end
  end

  assign set_time     = set_q;
  assign count_time   = cnt_q;
  assign timer_done   = (cnt_q == ZERO_TIME);
  assign display_time = prog_mode ? set_q : cnt_q;

`ifdef COUNTDOWN_ALARM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      alarm <= 1'b0;
    else if (load_timer || prog_mode)
      alarm <= 1'b0;
    else if (dec_en && cnt_q == ONE_SEC)
      alarm <= 1'b1;
  end
`endif

endmodule
